seq_mem_nport_pipe: RTL and testbench
=====================================

SEQ_MEM_NPORT_PIPE -- requirements
Module: seq_mem_nport_pipe

Interface
REQ-001 Parameter WIDTH, default 32: data bits per word; SHALL be a multiple of 8.
REQ-002 Parameter SIZE, default 16: number of words.
REQ-003 Parameter IDX_SIZE, default 4: address bits; SHALL satisfy 2**IDX_SIZE >= SIZE.
REQ-004 Parameter NUM_PORTS, default 4: independent request ports, 1..8.
REQ-005 Parameter LATENCY, default 5: cycles from request accept to done; SHALL be 1..8.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 content_en  input  NUM_PORTS  per-port request strobe; bit i issues a request this cycle.
REQ-009 write_en  input  NUM_PORTS  per-port op select: 1 = write, 0 = read.
REQ-010 addr  input  NUM_PORTS*IDX_SIZE  per-port word address; port i at slice [i*IDX_SIZE +: IDX_SIZE].
REQ-011 write_data  input  NUM_PORTS*WIDTH  per-port write word.
REQ-012 write_strb  input  NUM_PORTS*(WIDTH/8)  per-port byte enables for writes.
REQ-013 done  output  NUM_PORTS  one-cycle completion pulse per port.
REQ-014 read_data  output  NUM_PORTS*WIDTH  per-port response word, valid when done[i] is high.
REQ-015 err  output  NUM_PORTS  out-of-bounds flag, valid when done[i] is high.

Function
REQ-016 Every cycle with content_en[i]=1 SHALL accept a request on port i; there is no back-pressure, and one request per port per cycle is sustained.
REQ-017 Memory access SHALL occur at the accept edge: reads sample the array contents from before that edge, and writes commit at that edge.
REQ-018 done[i] SHALL pulse exactly LATENCY cycles after the accept edge, with read_data[i] and err[i] aligned to it.
REQ-019 Read response: read_data = mem[addr].
REQ-020 Write response: read_data = the word's contents before the write (old data); the written bytes are those with write_strb bit k = 1, and unselected bytes are unchanged.
REQ-021 Read-after-write: a read accepted one or more cycles after a write to the same address SHALL return the new data.
REQ-022 Same-cycle read and write to one address on different ports: the read SHALL return old data.
REQ-023 Same-cycle writes to one address on several ports SHALL merge per byte, and the lowest-index port enabling a byte wins that byte.
REQ-024 addr >= SIZE: the write is suppressed, read_data = 0, and err = 1 with done.
REQ-025 When done[i] = 0, read_data[i] and err[i] SHALL hold their last response values.
REQ-026 write_en, addr, write_data and write_strb are ignored when content_en[i] = 0.

Reset
REQ-027 Asserting reset SHALL immediately clear done, read_data and err to 0, along with all pipeline valid bits.
REQ-028 Requests in flight when reset asserts SHALL be dropped and never produce done; writes already committed SHALL persist.
REQ-029 Array contents SHALL NOT be reset.
REQ-030 content_en SHALL be ignored while reset is high, and accepts resume on the first edge after deassertion.

Structure
REQ-031 Package seq_mem_pkg SHALL hold the default parameter constants, MAX_PORTS = 8, MAX_LATENCY = 8, and a byte-strobe merge function.
REQ-032 Sub-module seq_mem_delay_pipe SHALL be instantiated once per port: a LATENCY-stage shift register of {valid, err, data} with async reset of the valid bits only.
REQ-033 Elaboration SHALL fail when any parameter rule in REQ-001 to REQ-005 is violated.

Verification
REQ-034 Defaults: port0 write addr 3 data 0xDEADBEEF strb 0xF; next cycle, port1 reads addr 3 -> port1 done at 5 cycles with 0xDEADBEEF, and port0 done with the prior contents.
REQ-035 Same cycle: port0 writes addr 2 data 0x11111111 strb 0x3 and port2 writes addr 2 data 0x22222222 strb 0xF, over prior 0 -> a later read returns 0x22221111.
REQ-036 Same cycle: port1 reads addr 7 and port3 writes addr 7 data 0x5, over prior 0x9 -> port1 returns 0x9; a read in the next cycle returns 0x5.
REQ-037 Read addr 20 with SIZE = 16, IDX_SIZE = 5 -> done with err = 1 and data 0; a write to addr 20 leaves all words unchanged.
REQ-038 Reset asserted 2 cycles after a read accept -> outputs go 0 immediately, and no done appears for that request.
REQ-039 NUM_PORTS = 2, LATENCY = 1, WIDTH = 64 -> back-to-back requests every cycle on both ports, with a 1-cycle done each, checked against a reference model over 10k random ops.

Source files
------------

// File: rtl/seq_mem_pkg.sv
// seq_mem_pkg
// Shared constants and helpers for the multi-port pipelined word memory.
//   DEF_*        : default values of the top-level parameters
//   MAX_PORTS    : upper bound on the number of request ports
//   MAX_LATENCY  : upper bound on the request-to-done latency
//   op_e         : per-port operation encoding carried on write_en
//   strb_merge_byte : applies one byte-enable bit to one byte lane
package seq_mem_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_SIZE      = 16;
  localparam int DEF_IDX_SIZE  = 4;
  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_LATENCY   = 5;
  localparam int MAX_PORTS     = 8;
  localparam int MAX_LATENCY   = 8;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  function automatic logic [7:0] strb_merge_byte(input logic [7:0] cur_b,
                                                 input logic [7:0] new_b,
                                                 input logic       en);
    return en ? new_b : cur_b;
  endfunction

endpackage

// File: rtl/seq_mem_nport_pipe_if.sv
// seq_mem_nport_pipe_if
// Request/response bundle of the multi-port memory, all ports flattened.
//   content_en [NUM_PORTS]           request strobe per port
//   write_en   [NUM_PORTS]           1 = write, 0 = read
//   addr       [NUM_PORTS*IDX_SIZE]  word address, port i at [i*IDX_SIZE +: IDX_SIZE]
//   write_data [NUM_PORTS*WIDTH]     write word per port
//   write_strb [NUM_PORTS*WIDTH/8]   byte enables per port
//   done       [NUM_PORTS]           one-cycle completion pulse
//   read_data  [NUM_PORTS*WIDTH]     response word (held between pulses)
//   err        [NUM_PORTS]           out-of-range flag (held between pulses)
// master drives requests, slave (the memory) drives responses.
interface seq_mem_nport_pipe_if
  import seq_mem_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int IDX_SIZE  = DEF_IDX_SIZE,
  parameter int NUM_PORTS = DEF_NUM_PORTS
);

  logic [NUM_PORTS-1:0]             content_en;
  logic [NUM_PORTS-1:0]             write_en;
  logic [NUM_PORTS*IDX_SIZE-1:0]    addr;
  logic [NUM_PORTS*WIDTH-1:0]       write_data;
  logic [NUM_PORTS*(WIDTH/8)-1:0]   write_strb;
  logic [NUM_PORTS-1:0]             done;
  logic [NUM_PORTS*WIDTH-1:0]       read_data;
  logic [NUM_PORTS-1:0]             err;

  modport master (
    output content_en, write_en, addr, write_data, write_strb,
    input  done, read_data, err
  );

  modport slave (
    input  content_en, write_en, addr, write_data, write_strb,
    output done, read_data, err
  );

endinterface

// File: rtl/seq_mem_delay_pipe.sv
// seq_mem_delay_pipe
// LATENCY-stage shift register carrying one response {valid, err, data}.
// Only the valid bits are reset so in-flight responses vanish on reset;
// err/data are free-running payload.
//   clk, reset (async, active-high)
//   in_vld/in_err/in_data    : response captured at the accept edge
//   out_vld/out_err/out_data : response after LATENCY edges
module seq_mem_delay_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_vld,
  input  logic             in_err,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic             out_err,
  output logic [WIDTH-1:0] out_data
);

  logic [LATENCY-1:0] vld_p;
  logic [LATENCY-1:0] err_p;
  logic [WIDTH-1:0]   data_p [LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= in_vld;
      for (int k = 1; k < LATENCY; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  always_ff @(posedge clk) begin
    err_p[0]  <= in_err;
    data_p[0] <= in_data;
    for (int k = 1; k < LATENCY; k++) begin
      err_p[k]  <= err_p[k-1];
      data_p[k] <= data_p[k-1];
    end
  end

  assign out_vld  = vld_p[LATENCY-1];
  assign out_err  = err_p[LATENCY-1];
  assign out_data = data_p[LATENCY-1];

endmodule

// File: rtl/seq_mem_nport_pipe.sv
// seq_mem_nport_pipe
// SIZE x WIDTH word memory with NUM_PORTS independent request ports. Every
// request is served at its accept edge (read returns pre-edge contents,
// writes commit at that edge) and its response emerges LATENCY edges later
// as a one-cycle done pulse. Writes return the old word. Same-edge writes to
// one word merge per byte with the lowest port winning each byte.
//   clk   : clock
//   reset : async active-high; clears responses and in-flight requests,
//           leaves the array untouched
//   bus   : seq_mem_nport_pipe_if.slave request/response bundle
module seq_mem_nport_pipe
  import seq_mem_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int SIZE      = DEF_SIZE,
  parameter int IDX_SIZE  = DEF_IDX_SIZE,
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int LATENCY   = DEF_LATENCY
) (
  input logic                  clk,
  input logic                  reset,
  seq_mem_nport_pipe_if.slave  bus
);

  localparam int                NB     = WIDTH / 8;
  localparam logic [IDX_SIZE:0] SIZE_W = (IDX_SIZE + 1)'(SIZE);

  if (WIDTH < 8 || (WIDTH % 8) != 0) begin : g_bad_width
    $error("seq_mem_nport_pipe: WIDTH must be a positive multiple of 8");
  end
  if (SIZE < 1 || (64'd1 << IDX_SIZE) < 64'(SIZE)) begin : g_bad_size
    $error("seq_mem_nport_pipe: need SIZE >= 1 and 2**IDX_SIZE >= SIZE");
  end
  if (NUM_PORTS < 1 || NUM_PORTS > MAX_PORTS) begin : g_bad_ports
    $error("seq_mem_nport_pipe: NUM_PORTS out of range 1..8");
  end
  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("seq_mem_nport_pipe: LATENCY out of range 1..8");
  end

  logic [WIDTH-1:0]     mem     [SIZE];
  logic [WIDTH-1:0]     mem_nxt [SIZE];

  logic [NUM_PORTS-1:0] fire_p0;
  logic [NUM_PORTS-1:0] wr_p0;
  logic [NUM_PORTS-1:0] oob_p0;
  logic [IDX_SIZE-1:0]  addr_p0 [NUM_PORTS];
  logic [WIDTH-1:0]     rd_p0   [NUM_PORTS];

  logic [NUM_PORTS-1:0] vld_p1;
  logic [NUM_PORTS-1:0] err_p1;
  logic [WIDTH-1:0]     data_p1 [NUM_PORTS];

  logic [NUM_PORTS-1:0]       done_p2;
  logic [NUM_PORTS-1:0]       err_p2;
  logic [NUM_PORTS*WIDTH-1:0] rdata_p2;

  // Stage p0: request decode and array access at the accept edge.
  // Requests are masked while reset is high so nothing is accepted or written.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      addr_p0[p] = bus.addr[p*IDX_SIZE +: IDX_SIZE];
      fire_p0[p] = bus.content_en[p] & ~reset;
      wr_p0[p]   = (op_e'(bus.write_en[p]) == OP_WRITE);
      oob_p0[p]  = ({1'b0, addr_p0[p]} >= SIZE_W);
      rd_p0[p]   = '0;
      for (int w = 0; w < SIZE; w++) begin
        if (addr_p0[p] == IDX_SIZE'(w)) rd_p0[p] = mem[w];
      end
    end
  end

  // Ports are applied highest first so the lowest enabling port lands last
  // and owns each byte. Out-of-range addresses never match a word.
  always_comb begin
    mem_nxt = mem;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (fire_p0[p] && wr_p0[p]) begin
        for (int w = 0; w < SIZE; w++) begin
          if (addr_p0[p] == IDX_SIZE'(w)) begin
            for (int b = 0; b < NB; b++) begin
              mem_nxt[w][8*b +: 8] = strb_merge_byte(mem_nxt[w][8*b +: 8],
                                                     bus.write_data[p*WIDTH + 8*b +: 8],
                                                     bus.write_strb[p*NB + b]);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int w = 0; w < SIZE; w++) mem[w] <= mem_nxt[w];
  end

  // Stage p1: LATENCY-deep delay line per port; the p0 response enters at
  // the accept edge.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    seq_mem_delay_pipe #(
      .WIDTH   (WIDTH),
      .LATENCY (LATENCY)
    ) u_delay (
      .clk      (clk),
      .reset    (reset),
      .in_vld   (fire_p0[p]),
      .in_err   (oob_p0[p]),
      .in_data  (oob_p0[p] ? '0 : rd_p0[p]),
      .out_vld  (vld_p1[p]),
      .out_err  (err_p1[p]),
      .out_data (data_p1[p])
    );
  end

  // Stage p2: response registers; payload only loads on a completing
  // request so read_data/err hold between done pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_p2  <= '0;
      err_p2   <= '0;
      rdata_p2 <= '0;
    end else begin
      done_p2 <= vld_p1;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (vld_p1[p]) begin
          err_p2[p]                   <= err_p1[p];
          rdata_p2[p*WIDTH +: WIDTH]  <= data_p1[p];
        end
      end
    end
  end

  assign bus.done      = done_p2;
  assign bus.err       = err_p2;
  assign bus.read_data = rdata_p2;

endmodule

// File: tb/tb_seq_mem_nport_pipe.sv
// tb_seq_mem_nport_pipe
// Two instances: A (32-bit, 16 words, 5-bit address, 4 ports, latency 5)
// runs directed vectors with hand-computed responses; B (64-bit, 2 ports,
// latency 1) runs back-to-back traffic against a reference memory model.
// Stimulus pushes expected responses into per-port queues; the monitors pop
// and compare on every done pulse.
module tb_seq_mem_nport_pipe;

  localparam int LAT_A = 5;
  localparam int LAT_B = 1;

  typedef struct {
    int          due;
    logic [63:0] data;
    logic        err;
    logic        chk;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_mem_nport_pipe_if #(.WIDTH(32), .IDX_SIZE(5), .NUM_PORTS(4)) bus_a ();
  seq_mem_nport_pipe_if #(.WIDTH(64), .IDX_SIZE(4), .NUM_PORTS(2)) bus_b ();

  seq_mem_nport_pipe #(
    .WIDTH(32), .SIZE(16), .IDX_SIZE(5), .NUM_PORTS(4), .LATENCY(LAT_A)
  ) dut_a (.clk(clk), .reset(reset), .bus(bus_a));

  seq_mem_nport_pipe #(
    .WIDTH(64), .SIZE(16), .IDX_SIZE(4), .NUM_PORTS(2), .LATENCY(LAT_B)
  ) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  exp_t        qa [4][$];
  exp_t        qb [2][$];
  logic [31:0] xd_a [4];
  logic        xe_a [4];
  logic        xc_a [4];
  logic [63:0] mdl_b [16];
  logic [31:0] last_rd_a [4];
  logic        last_er_a [4];
  logic [63:0] last_rd_b [2];
  logic        last_er_b [2];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
  endtask

  function automatic logic [31:0] init_val(input int w);
    if (w == 2) return 32'h0;
    if (w == 7) return 32'h9;
    return 32'hA500_0000 | 32'(w);
  endfunction

  // ---------------- instance A stimulus ----------------
  task automatic req_a(input int p, input logic we, input logic [4:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] xd, input logic xe, input logic xc);
    bus_a.content_en[p]        = 1'b1;
    bus_a.write_en[p]          = we;
    bus_a.addr[p*5 +: 5]       = a;
    bus_a.write_data[p*32 +: 32] = d;
    bus_a.write_strb[p*4 +: 4] = s;
    xd_a[p] = xd;
    xe_a[p] = xe;
    xc_a[p] = xc;
  endtask

  // Idle fields are left as all-ones writes to word 3: a design that
  // ignored content_en would corrupt that word.
  task automatic idle_a();
    bus_a.content_en = '0;
    bus_a.write_en   = '1;
    bus_a.addr       = {4{5'd3}};
    bus_a.write_data = '1;
    bus_a.write_strb = '1;
  endtask

  task automatic issue_a();
    for (int p = 0; p < 4; p++) begin
      if (bus_a.content_en[p])
        qa[p].push_back('{due: cyc + 1 + LAT_A, data: 64'(xd_a[p]), err: xe_a[p], chk: xc_a[p]});
    end
    @(posedge clk);
    #1;
    idle_a();
  endtask

  // ---------------- instance B stimulus + reference model ----------------
  task automatic issue_b();
    logic [3:0]  a;
    logic [63:0] d;
    for (int p = 0; p < 2; p++) begin
      if (bus_b.content_en[p]) begin
        a = bus_b.addr[p*4 +: 4];
        qb[p].push_back('{due: cyc + 1 + LAT_B, data: mdl_b[a], err: 1'b0,
                          chk: !$isunknown(mdl_b[a])});
      end
    end
    for (int p = 1; p >= 0; p--) begin
      if (bus_b.content_en[p] && bus_b.write_en[p]) begin
        a = bus_b.addr[p*4 +: 4];
        d = bus_b.write_data[p*64 +: 64];
        for (int b = 0; b < 8; b++)
          if (bus_b.write_strb[p*8 + b]) mdl_b[a][8*b +: 8] = d[8*b +: 8];
      end
    end
    @(posedge clk);
    #1;
    bus_b.content_en = '0;
  endtask

  task automatic req_b(input int p, input logic we, input logic [3:0] a,
                       input logic [63:0] d, input logic [7:0] s);
    bus_b.content_en[p]          = 1'b1;
    bus_b.write_en[p]            = we;
    bus_b.addr[p*4 +: 4]         = a;
    bus_b.write_data[p*64 +: 64] = d;
    bus_b.write_strb[p*8 +: 8]   = s;
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (reset) begin
      for (int p = 0; p < 4; p++) begin last_rd_a[p] = '0; last_er_a[p] = 1'b0; end
    end else begin
      for (int p = 0; p < 4; p++) begin
        logic [31:0] rd;
        logic        er;
        exp_t        e;
        rd = bus_a.read_data[p*32 +: 32];
        er = bus_a.err[p];
        if (bus_a.done[p]) begin
          if (qa[p].size() == 0) begin
            check($sformatf("a%0d_unexpected_done", p), 64'(bus_a.done[p]), 64'd0);
          end else begin
            e = qa[p].pop_front();
            check($sformatf("a%0d_done_cycle", p), 64'(cyc), 64'(e.due));
            if (e.chk) check($sformatf("a%0d_read_data", p), 64'(rd), e.data);
            check($sformatf("a%0d_err", p), 64'(er), 64'(e.err));
          end
          last_rd_a[p] = rd;
          last_er_a[p] = er;
        end else begin
          check($sformatf("a%0d_hold_data", p), 64'(rd), 64'(last_rd_a[p]));
          check($sformatf("a%0d_hold_err", p), 64'(er), 64'(last_er_a[p]));
          if (qa[p].size() != 0 && qa[p][0].due <= cyc) begin
            check($sformatf("a%0d_missing_done", p), 64'(bus_a.done[p]), 64'd1);
            void'(qa[p].pop_front());
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin last_rd_b[p] = '0; last_er_b[p] = 1'b0; end
    end else begin
      for (int p = 0; p < 2; p++) begin
        logic [63:0] rd;
        logic        er;
        exp_t        e;
        rd = bus_b.read_data[p*64 +: 64];
        er = bus_b.err[p];
        if (bus_b.done[p]) begin
          if (qb[p].size() == 0) begin
            check($sformatf("b%0d_unexpected_done", p), 64'(bus_b.done[p]), 64'd0);
          end else begin
            e = qb[p].pop_front();
            check($sformatf("b%0d_done_cycle", p), 64'(cyc), 64'(e.due));
            if (e.chk) check($sformatf("b%0d_read_data", p), rd, e.data);
            check($sformatf("b%0d_err", p), 64'(er), 64'(e.err));
          end
          last_rd_b[p] = rd;
          last_er_b[p] = er;
        end else begin
          check($sformatf("b%0d_hold_data", p), rd, last_rd_b[p]);
          check($sformatf("b%0d_hold_err", p), 64'(er), 64'(last_er_b[p]));
          if (qb[p].size() != 0 && qb[p][0].due <= cyc) begin
            check($sformatf("b%0d_missing_done", p), 64'(bus_b.done[p]), 64'd1);
            void'(qb[p].pop_front());
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int left;
    idle_a();
    bus_b.content_en = '0;
    bus_b.write_en   = '0;
    bus_b.addr       = '0;
    bus_b.write_data = '0;
    bus_b.write_strb = '0;
    for (int w = 0; w < 16; w++) mdl_b[w] = 'x;

    // Reset state.
    repeat (2) @(negedge clk);
    check("a_reset_done", 64'(bus_a.done), 64'd0);
    check("a_reset_read_data", 64'(bus_a.read_data), 64'd0);
    check("a_reset_err", 64'(bus_a.err), 64'd0);
    check("b_reset_done", 64'(bus_b.done), 64'd0);
    check("b_reset_read_data", 64'(bus_b.read_data[63:0]), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Fill A: four words per cycle, old data unknown so only err is checked.
    for (int c = 0; c < 4; c++) begin
      for (int p = 0; p < 4; p++)
        req_a(p, 1'b1, 5'(4*c + p), init_val(4*c + p), 4'hF, 32'h0, 1'b0, 1'b0);
      issue_a();
    end

    // Write then read-after-write on another port.
    req_a(0, 1'b1, 5'd3, 32'hDEADBEEF, 4'hF, 32'hA500_0003, 1'b0, 1'b1);
    issue_a();
    req_a(1, 1'b0, 5'd3, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    issue_a();

    // Same-edge writes merge per byte, lowest port wins.
    req_a(0, 1'b1, 5'd2, 32'h1111_1111, 4'h3, 32'h0, 1'b0, 1'b1);
    req_a(2, 1'b1, 5'd2, 32'h2222_2222, 4'hF, 32'h0, 1'b0, 1'b1);
    issue_a();
    req_a(3, 1'b0, 5'd2, 32'h0, 4'h0, 32'h2222_1111, 1'b0, 1'b1);
    issue_a();

    // Same-edge read and write: read sees old data, next read sees new.
    req_a(1, 1'b0, 5'd7, 32'h0, 4'h0, 32'h9, 1'b0, 1'b1);
    req_a(3, 1'b1, 5'd7, 32'h5, 4'hF, 32'h9, 1'b0, 1'b1);
    issue_a();
    req_a(0, 1'b0, 5'd7, 32'h0, 4'h0, 32'h5, 1'b0, 1'b1);
    issue_a();

    // Partial strobe: bytes 1 and 3 only.
    req_a(2, 1'b1, 5'd5, 32'h7766_5544, 4'b1010, 32'hA500_0005, 1'b0, 1'b1);
    issue_a();
    req_a(2, 1'b0, 5'd5, 32'h0, 4'h0, 32'h7700_5505, 1'b0, 1'b1);
    issue_a();

    // Out-of-range addresses (SIZE and above) and the last valid word.
    req_a(0, 1'b0, 5'd20, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
    req_a(1, 1'b1, 5'd20, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1'b1);
    req_a(2, 1'b1, 5'd16, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1'b1);
    req_a(3, 1'b0, 5'd15, 32'h0, 4'h0, 32'hA500_000F, 1'b0, 1'b1);
    issue_a();
    req_a(0, 1'b0, 5'd4, 32'h0, 4'h0, 32'hA500_0004, 1'b0, 1'b1);
    req_a(1, 1'b0, 5'd0, 32'h0, 4'h0, 32'hA500_0000, 1'b0, 1'b1);
    req_a(2, 1'b0, 5'd31, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
    req_a(3, 1'b0, 5'd20, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
    issue_a();
    repeat (LAT_A + 2) @(posedge clk);
    #1;

    // Reset two cycles after a read accept: outputs clear at once, the read
    // never completes, a request during reset is ignored.
    req_a(0, 1'b0, 5'd3, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    issue_a();
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    for (int p = 0; p < 4; p++) qa[p].delete();
    for (int p = 0; p < 2; p++) qb[p].delete();
    #1;
    check("a_async_reset_done", 64'(bus_a.done), 64'd0);
    check("a_async_reset_read_data", 64'(bus_a.read_data), 64'd0);
    check("a_async_reset_err", 64'(bus_a.err), 64'd0);
    req_a(1, 1'b1, 5'd3, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    idle_a();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (LAT_A + 3) @(posedge clk);
    #1;
    req_a(0, 1'b0, 5'd3, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    req_a(1, 1'b0, 5'd2, 32'h0, 4'h0, 32'h2222_1111, 1'b0, 1'b1);
    req_a(2, 1'b0, 5'd7, 32'h0, 4'h0, 32'h5, 1'b0, 1'b1);
    issue_a();

    // B: fill, then back-to-back traffic on both ports every cycle.
    for (int c = 0; c < 8; c++) begin
      req_b(0, 1'b1, 4'(2*c), {$urandom, $urandom}, 8'hFF);
      req_b(1, 1'b1, 4'(2*c + 1), {$urandom, $urandom}, 8'hFF);
      issue_b();
    end
    for (int i = 0; i < 5000; i++) begin
      for (int p = 0; p < 2; p++) begin
        logic [3:0] a;
        a = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        req_b(p, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom_range(0, 255)));
      end
      issue_b();
    end
    repeat (LAT_A + 3) @(posedge clk);
    #1;

    left = 0;
    for (int p = 0; p < 4; p++) left += qa[p].size();
    check("a_pending_at_end", 64'(left), 64'd0);
    left = 0;
    for (int p = 0; p < 2; p++) left += qb[p].size();
    check("b_pending_at_end", 64'(left), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
